// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus types plus the SRAM responder's FSM encoding and beat limit.
package cbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // Encoded as beat count minus one.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_WAIT  = 2'd1,
    CS_BURST = 2'd2
  } cbus_sram_state_t;

  localparam int CBUS_MAX_BEATS = 16;

endpackage

// File: rtl/cbus_sram_responder_bank.sv
// Single-port byte-strobed 32-bit SRAM, registered read, write-first.
module cbus_sram_bank
  import cbus_sram_responder_pkg::*;
#(
  parameter int AW        = 14,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    strobe,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] merged;

  // Word as it will look after this cycle's strobed write.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++)
      if (strobe[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  // Byte-enabled write port; memory is never reset.
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (strobe[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  // Registered read; a write returns the merged word (write-first).
  always_ff @(posedge clk) begin
    if (!resetn)  rdata <= '0;
    else if (we)  rdata <= merged;
    else if (en)  rdata <= mem[addr];
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus responder serving single/burst reads and writes from on-chip SRAM.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp
);

  localparam int BW = $clog2(CBUS_MAX_BEATS + 1);

  cbus_sram_state_t      state;
  logic [3:0]            cnt;
  logic [BW-1:0]         beat;
  logic [BW-1:0]         nbeats;
  logic [DEPTH_LOG2-1:0] ptr;
  logic                  is_wr;
  logic                  ready_q;
  logic                  last_q;

  logic [DEPTH_LOG2-1:0] addr_in;
  logic [DEPTH_LOG2-1:0] bank_addr;
  logic                  bank_en;
  logic                  bank_we;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign addr_in     = ireq.addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{ireq.size, ireq.addr[1:0], ireq.addr[31:DEPTH_LOG2+2]};

  // Read address runs one beat ahead so data lands with ready; writes use ptr.
  always_comb begin
    bank_addr = ptr;
    bank_en   = 1'b0;
    case (state)
      CS_IDLE: begin
        bank_addr = addr_in;
        bank_en   = ireq.valid && !ireq.is_write && (LATENCY == 0);
      end
      CS_WAIT:  bank_en = ireq.valid && !is_wr && (cnt <= 4'd1);
      CS_BURST: begin
        bank_addr = is_wr ? ptr : ptr + DEPTH_LOG2'(1);
        bank_en   = ireq.valid && !is_wr && !last_q;
      end
      default: ;
    endcase
  end

  // Write only on a live beat; an abort cycle or reset edge drops it.
  assign bank_we = resetn && ireq.valid && is_wr && (state == CS_BURST);

  cbus_sram_bank #(.AW(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_bank (
    .clk    (clk),
    .resetn (resetn),
    .en     (bank_en),
    .we     (bank_we),
    .addr   (bank_addr),
    .strobe (ireq.strobe),
    .wdata  (ireq.data),
    .rdata  (rdata)
  );

  // Transaction FSM: capture on accept, count latency, stream beats.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= CS_IDLE;
      cnt     <= '0;
      beat    <= '0;
      nbeats  <= '0;
      ptr     <= '0;
      is_wr   <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        CS_IDLE: begin
          ready_q <= 1'b0;
          last_q  <= 1'b0;
          if (ireq.valid) begin
            ptr    <= addr_in;
            is_wr  <= ireq.is_write;
            nbeats <= BW'(ireq.len) + BW'(1);
            beat   <= '0;
            cnt    <= 4'(LATENCY);
            if (LATENCY == 0) begin
              state   <= CS_BURST;
              ready_q <= 1'b1;
              last_q  <= (ireq.len == MLEN1);
            end else begin
              state <= CS_WAIT;
            end
          end
        end
        CS_WAIT: begin
          if (!ireq.valid) begin
            state <= CS_IDLE;
          end else if (cnt <= 4'd1) begin
            state   <= CS_BURST;
            ready_q <= 1'b1;
            last_q  <= (nbeats == BW'(1));
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CS_BURST: begin
          if (!ireq.valid || last_q) begin
            state   <= CS_IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            ptr    <= ptr + DEPTH_LOG2'(1);
            beat   <= beat + BW'(1);
            last_q <= (beat + BW'(2) == nbeats);
          end
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

  // Response bundle; write beats return zero data.
  always_comb begin
    iresp       = '0;
    iresp.ready = ready_q;
    iresp.last  = last_q;
    iresp.data  = is_wr ? 32'h0 : rdata;
  end

endmodule
